rgb2hsv: RTL and testbench



---
 rtl/rgb2hsv.sv | 232 +++++++++++++++++++++++
 tb/tb_rgb2hsv.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2hsv.sv
// rgb2hsv: converts one 24-bit RGB pixel into packed 8-bit {H,S,V}.
//
// A single 16-iteration restoring divider is shared in time: it first
// computes saturation (255*delta / max), then the hue offset
// (HUE_SEXTANT*|d| / delta). One pixel is in flight at a time, so the block
// suits frame-buffer sweeps rather than per-pixel-clock streaming.
// Latency is fixed: a pixel accepted at edge k gives out_valid after edge k+33.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   tRGB       {R[23:16], G[15:8], B[7:0]} input pixel
//   in_valid   tRGB valid
//   in_ready   block can accept a pixel (high only while idle)
//   tHSV       {H[23:16], S[15:8], V[7:0]}; held stable while out_valid
//   out_valid  tHSV valid
//   out_ready  consumer accepts tHSV

module rgb2hsv #(
  parameter int HUE_SEXTANT = 43,   // hue units per 60-degree sector
  parameter int HUE_G_BASE  = 85,   // hue offset when G is the maximum
  parameter int HUE_B_BASE  = 171   // hue offset when B is the maximum
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] tRGB,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] tHSV,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    DIV_S = 3'd2,
    DIV_H = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  // Captured pixel
  logic [7:0] r, g, b;
  logic [23:0] rgb_q;

  // Results
  logic [7:0] h_q, s_q, v_q;

  // Hue operands parked while the divider works on saturation
  logic [13:0] hue_num;
  logic [7:0]  hue_den;
  logic        hue_sign;
  logic [7:0]  hue_base;
  logic        grey;        // delta == 0: S and H forced to 0

  // Shared restoring divider: quotient shifts in where the dividend shifts out
  logic [15:0] div_rem;
  logic [15:0] div_quo;
  logic [7:0]  div_den;
  logic [3:0]  iter;

  // ---------------------------------------------------------------------------
  // PREP-stage combinational arithmetic on the captured pixel
  // ---------------------------------------------------------------------------
  logic       r_max, g_max;
  logic [7:0] max_c, min_c, delta;
  logic [7:0] d_abs;
  logic       d_neg;
  logic [7:0] base_c;

  assign r = rgb_q[23:16];
  assign g = rgb_q[15:8];
  assign b = rgb_q[7:0];

  // Ties resolve to R first, then G, then B.
  assign r_max = (r >= g) && (r >= b);
  assign g_max = !r_max && (g >= b);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    max_c  = b;
    d_abs  = 8'd0;
    d_neg  = 1'b0;
    base_c = 8'(HUE_B_BASE);
    if (r_max) begin
      max_c  = r;
      base_c = 8'd0;
      d_neg  = (g < b);
      d_abs  = d_neg ? (b - g) : (g - b);
    end else if (g_max) begin
      max_c  = g;
      base_c = 8'(HUE_G_BASE);
      d_neg  = (b < r);
      d_abs  = d_neg ? (r - b) : (b - r);
    end else begin
      d_neg  = (r < g);
      d_abs  = d_neg ? (g - r) : (r - g);
    end
  end

  always_comb begin
    min_c = r;
    if (g < min_c) min_c = g;
    if (b < min_c) min_c = b;
  end

  assign delta = max_c - min_c;

  logic [15:0] sat_num;
  logic [13:0] hue_num_c;
  assign sat_num   = {8'd0, delta} * 16'd255;
  assign hue_num_c = 14'(HUE_SEXTANT * int'(d_abs));

  // ---------------------------------------------------------------------------
  // One restoring division step
  // ---------------------------------------------------------------------------
  logic [16:0] div_shift, div_trial;
  logic        div_bit;
  logic [15:0] rem_step, quo_step;

  always_comb begin
    div_shift = {div_rem, div_quo[15]};
    div_trial = div_shift - {9'd0, div_den};
    div_bit   = !div_trial[16];
    rem_step  = div_bit ? div_trial[15:0] : div_shift[15:0];
    quo_step  = {div_quo[14:0], div_bit};
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = PREP;
      PREP:                           state_next = DIV_S;
      DIV_S:   if (iter == 4'd15)     state_next = DIV_H;
      DIV_H:   if (iter == 4'd15)     state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    tHSV      = {h_q, s_q, v_q};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: all datapath registers are reset so an aborted conversion leaves no
  // residue and tHSV reads 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q    <= '0;
      h_q      <= '0;
      s_q      <= '0;
      v_q      <= '0;
      hue_num  <= '0;
      hue_den  <= '0;
      hue_sign <= 1'b0;
      hue_base <= '0;
      grey     <= 1'b0;
      div_rem  <= '0;
      div_quo  <= '0;
      div_den  <= '0;
      iter     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) rgb_q <= tRGB;
          iter <= '0;
        end

        PREP: begin
          v_q      <= max_c;
          grey     <= (delta == 8'd0);
          hue_num  <= hue_num_c;
          hue_den  <= (delta == 8'd0) ? 8'd1 : delta;
          hue_sign <= d_neg;
          hue_base <= base_c;
          div_rem  <= '0;
          div_quo  <= sat_num;
          div_den  <= (max_c == 8'd0) ? 8'd1 : max_c;
          iter     <= '0;
        end

        DIV_S: begin
          div_rem <= rem_step;
          div_quo <= quo_step;
          iter    <= iter + 4'd1;
          if (iter == 4'd15) begin
            s_q     <= grey ? 8'd0 : quo_step[7:0];
            // Reload the divider with the hue operands for the next phase.
            div_rem <= '0;
            div_quo <= {2'b00, hue_num};
            div_den <= hue_den;
          end
        end

        DIV_H: begin
          div_rem <= rem_step;
          div_quo <= quo_step;
          iter    <= iter + 4'd1;
          if (iter == 4'd15) begin
            // 8-bit arithmetic gives the mod-256 wrap of a negative offset.
            if (grey)          h_q <= 8'd0;
            else if (hue_sign) h_q <= hue_base - quo_step[7:0];
            else               h_q <= hue_base + quo_step[7:0];
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2hsv.sv
// Directed-vector testbench for rgb2hsv.
module tb_rgb2hsv;

  logic        clk;
  logic        reset;
  logic [23:0] tRGB;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] tHSV;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int LAT     = 33;
  localparam int TIMEOUT = 200;

  rgb2hsv dut (
    .clk       (clk),
    .reset     (reset),
    .tRGB      (tRGB),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tHSV      (tHSV),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for in_ready at a negedge, then present the pixel and let
  // the next rising edge take it. Returns with in_valid dropped, #1 after the
  // accept edge.
  task automatic accept_pixel(input logic [23:0] rgb, input string name);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    tRGB     = rgb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic wait_result(input string name, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
  endtask

  task automatic check_hsv(input string name, input logic [23:0] exp);
    n_checks++;
    if (tHSV !== exp) begin
      n_fail++;
      $display("FAIL %s tHSV: got %0d,%0d,%0d want %0d,%0d,%0d", name,
               tHSV[23:16], tHSV[15:8], tHSV[7:0], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  // Consume the output with a one-cycle out_ready pulse.
  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after handshake: out_valid=%b in_ready=%b want 0,1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic convert(input logic [23:0] rgb, input logic [23:0] exp,
                         input string name);
    int lat;
    accept_pixel(rgb, name);
    wait_result(name, lat);
    check_hsv(name, exp);
    consume(name);
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || tHSV !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b tHSV=%h want 0,1,000000",
               out_valid, in_ready, tHSV);
    end
  endtask

  task automatic test_primaries();
    convert({8'd255, 8'd0,   8'd0},   {8'd0,   8'd255, 8'd255}, "red");
    convert({8'd0,   8'd255, 8'd0},   {8'd85,  8'd255, 8'd255}, "green");
    convert({8'd0,   8'd0,   8'd255}, {8'd171, 8'd255, 8'd255}, "blue");
  endtask

  task automatic test_grey();
    convert({8'd128, 8'd128, 8'd128}, {8'd0, 8'd0, 8'd128}, "grey");
    convert({8'd0,   8'd0,   8'd0},   {8'd0, 8'd0, 8'd0},   "black");
  endtask

  task automatic test_hue_wrap();
    // 43*128/255 = 21 truncated, negative -> 256-21
    convert({8'd255, 8'd0,  8'd128}, {8'd235, 8'd255, 8'd255}, "neg_wrap");
    // delta 75: S = 19125/100 = 191, H = 1075/75 = 14
    convert({8'd100, 8'd50, 8'd25},  {8'd14,  8'd191, 8'd100}, "trunc");
  endtask

  task automatic test_tie_priority();
    // R wins the R/G tie: d = G-B = 150, q = 43
    convert({8'd200, 8'd200, 8'd50},  {8'd43,  8'd191, 8'd200}, "tie_rg");
    // G wins the G/B tie: d = B-R = 150, q = 43, H = 85+43
    convert({8'd50,  8'd200, 8'd200}, {8'd128, 8'd191, 8'd200}, "tie_gb");
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    accept_pixel({8'd0, 8'd255, 8'd0}, "bp");
    wait_result("bp", lat);
    check_hsv("bp", {8'd85, 8'd255, 8'd255});
    // Present a pending pixel while the output is stalled.
    @(negedge clk);
    tRGB     = {8'd100, 8'd50, 8'd25};
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tHSV !== {8'd85, 8'd255, 8'd255} || in_ready !== 1'b0 ||
          out_valid !== 1'b1)
        bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d stalled cycles changed tHSV/in_ready/out_valid, want 0", bad);
    end
    // One-cycle out_ready: handshake edge returns to IDLE.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1,0", in_ready, out_valid);
    end
    // Pending pixel is taken on the next edge.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pending_accept: in_ready=%b want 0", in_ready);
    end
    wait_result("bp_pending", lat);
    check_hsv("bp_pending", {8'd14, 8'd191, 8'd100});
    consume("bp_pending");
  endtask

  task automatic test_reset_mid_div();
    accept_pixel({8'd255, 8'd0, 8'd128}, "abort");
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || tHSV !== 24'd0) begin
      n_fail++;
      $display("FAIL abort_reset: out_valid=%b in_ready=%b tHSV=%h want 0,1,000000",
               out_valid, in_ready, tHSV);
    end
    @(negedge clk);
    reset = 1'b0;
    convert({8'd100, 8'd50, 8'd25}, {8'd14, 8'd191, 8'd100}, "after_abort");
  endtask

  initial begin
    reset     = 1'b1;
    tRGB      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    test_primaries();
    test_grey();
    test_hue_wrap();
    test_tie_priority();
    test_backpressure();
    test_reset_mid_div();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
